// File: rtl/if_operand_packer_if.sv
// if_operand_packer_if: byte-stream input and operand-pair output bundle for the packer
interface if_operand_packer_if #(
    parameter int NA = 8,
    parameter int NB = 16
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_first;
    logic          in_ready;
    logic [NA-1:0] a;
    logic [NB-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    modport master (
        output in_data, in_valid, in_first, out_ready,
        input  in_ready, a, b, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, in_first, out_ready,
        output in_ready, a, b, out_valid, err
    );
endinterface

// File: rtl/if_operand_packer.sv
// if_operand_packer: assembles A/B operands from a byte stream; IF_PACK_CKSUM_EN adds a trailing XOR checksum byte
module if_operand_packer #(
    parameter int NA = 8,
    parameter int NB = 16
) (
    input logic                clk,
    input logic                rst_n,
    if_operand_packer_if.slave ifc
);
    localparam int FA = NA / 8;
    localparam int FB = NB / 8;
`ifdef IF_PACK_CKSUM_EN
    localparam int FL = FA + FB + 1;
`else
    localparam int FL = FA + FB;
`endif
    localparam int IW = $clog2(FL);
    localparam int SW = (FL - 1) * 8;
    localparam logic [IW-1:0] LAST_IDX = IW'(FL - 1);

    typedef enum logic {COLLECT, LAST} state_t;

    state_t           state;
    logic [IW-1:0]    idx, idx_n, wr_idx;
    logic [SW-1:0]    shadow, shadow_n;
    logic [NA-1:0]    a_q, a_n;
    logic [NB-1:0]    b_q, b_n;
    logic [NA+NB-1:0] frm;
    logic             ov_q, ov_n, err_q, err_n;
    logic             ready, acc, resync, fin, load, cks_ok;
`ifdef IF_PACK_CKSUM_EN
    logic [7:0]       xr, xr_n;
`endif

    assign state         = (idx == LAST_IDX) ? LAST : COLLECT;
    assign ready         = !(state == LAST && ov_q && !ifc.out_ready);
    assign ifc.in_ready  = ready;
    assign ifc.a         = a_q;
    assign ifc.b         = b_q;
    assign ifc.out_valid = ov_q;
    assign ifc.err       = err_q;

    // Next-state: byte acceptance, resync, frame completion and output slot update
    always_comb begin
        acc    = ifc.in_valid && ready;
        resync = acc && ifc.in_first && idx != '0;
        fin    = acc && !resync && state == LAST;
`ifdef IF_PACK_CKSUM_EN
        cks_ok = ifc.in_data == xr;
        frm    = shadow;
        xr_n   = !acc ? xr : (resync || idx == '0) ? ifc.in_data : xr ^ ifc.in_data;
`else
        cks_ok = 1'b1;
        frm    = {ifc.in_data, shadow};
`endif
        load   = fin && cks_ok;
        wr_idx = resync ? '0 : idx;
        idx_n  = !acc ? idx : resync ? IW'(1) : fin ? '0 : idx + IW'(1);
        shadow_n = shadow;
        for (int j = 0; j < FL - 1; j++)
            if (acc && (resync || state == COLLECT) && wr_idx == IW'(j))
                shadow_n[j*8 +: 8] = ifc.in_data;
        a_n   = load ? frm[NA-1:0] : a_q;
        b_n   = load ? frm[NA+NB-1:NA] : b_q;
        ov_n  = load || (ov_q && !ifc.out_ready);
        err_n = resync || (fin && !cks_ok);
    end

    // State and output registers; reset drops any partial frame silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            shadow <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
`ifdef IF_PACK_CKSUM_EN
            xr     <= '0;
`endif
        end else begin
            idx    <= idx_n;
            shadow <= shadow_n;
            a_q    <= a_n;
            b_q    <= b_n;
            ov_q   <= ov_n;
            err_q  <= err_n;
`ifdef IF_PACK_CKSUM_EN
            xr     <= xr_n;
`endif
        end
    end
endmodule

// File: tb/tb_if_operand_packer.sv
// tb_if_operand_packer: directed self-checking bench for if_operand_packer (NA=8, NB=16)
module tb_if_operand_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0;
    int   bad = 0;

    if_operand_packer_if #(.NA(8), .NB(16)) ifc ();

    if_operand_packer #(.NA(8), .NB(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ifc  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] d, input logic f, output int w);
        ifc.in_data  = d;
        ifc.in_first = f;
        ifc.in_valid = 1'b1;
        w = 0;
        #1;
        while (!ifc.in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 20) begin
            vec++;
            bad++;
            $display("FAIL send_timeout data=%h in_ready=%b exp=1", d, ifc.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, output int w);
        int t;
        w = 0;
        send(b0, 1'b1, t); w += t;
        send(b1, 1'b0, t); w += t;
        send(b2, 1'b0, t); w += t;
`ifdef IF_PACK_CKSUM_EN
        send(b0 ^ b1 ^ b2, 1'b0, t); w += t;
`endif
    endtask

    task automatic stop();
        ifc.in_valid = 1'b0;
        ifc.in_first = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stop();
        ifc.in_data = 8'h00;
        ifc.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vec++; if (ifc.a !== 8'h00) begin bad++; $display("FAIL reset_a got=%h exp=00", ifc.a); end
        vec++; if (ifc.b !== 16'h0000) begin bad++; $display("FAIL reset_b got=%h exp=0000", ifc.b); end
        vec++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", ifc.out_valid); end
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", ifc.err); end
        vec++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int w;
        ifc.out_ready = 1'b1;
        frame(8'h05, 8'h34, 8'h12, w);
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL single_ov got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h05) begin bad++; $display("FAIL single_a got=%h exp=05", ifc.a); end
        vec++; if (ifc.b !== 16'h1234) begin bad++; $display("FAIL single_b got=%h exp=1234", ifc.b); end
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", ifc.err); end
        vec++; if (w !== 0) begin bad++; $display("FAIL single_stalls got=%0d exp=0", w); end
        stop();
        @(negedge clk);
        vec++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL single_ov_drop got=%b exp=0", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h05) begin bad++; $display("FAIL single_a_hold got=%h exp=05", ifc.a); end
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        ifc.out_ready = 1'b1;
        frame(8'h01, 8'h02, 8'h00, w1);
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_ov1 got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h01) begin bad++; $display("FAIL b2b_a1 got=%h exp=01", ifc.a); end
        vec++; if (ifc.b !== 16'h0002) begin bad++; $display("FAIL b2b_b1 got=%h exp=0002", ifc.b); end
        frame(8'hFF, 8'hFF, 8'hFF, w2);
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_ov2 got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'hFF) begin bad++; $display("FAIL b2b_a2 got=%h exp=ff", ifc.a); end
        vec++; if (ifc.b !== 16'hFFFF) begin bad++; $display("FAIL b2b_b2 got=%h exp=ffff", ifc.b); end
        vec++; if (w1 + w2 !== 0) begin bad++; $display("FAIL b2b_stalls got=%0d exp=0", w1 + w2); end
        stop();
        @(negedge clk);
    endtask

    task automatic test_stall();
        int w, t;
        logic [7:0] lastb;
        ifc.out_ready = 1'b1;
        frame(8'h01, 8'h02, 8'h00, w);
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL stall_ov1 got=%b exp=1", ifc.out_valid); end
        ifc.out_ready = 1'b0;
        send(8'hAA, 1'b1, t);
        send(8'hBB, 1'b0, t);
`ifdef IF_PACK_CKSUM_EN
        send(8'hCC, 1'b0, t);
        lastb = 8'hAA ^ 8'hBB ^ 8'hCC;
`else
        lastb = 8'hCC;
`endif
        vec++; if (t !== 0) begin bad++; $display("FAIL stall_nonlast got=%0d exp=0", t); end
        ifc.in_data  = lastb;
        ifc.in_first = 1'b0;
        ifc.in_valid = 1'b1;
        #1;
        vec++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", ifc.in_ready); end
        repeat (3) @(negedge clk);
        #1;
        vec++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_hold got=%b exp=0", ifc.in_ready); end
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL stall_ov_hold got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h01) begin bad++; $display("FAIL stall_a_hold got=%h exp=01", ifc.a); end
        vec++; if (ifc.b !== 16'h0002) begin bad++; $display("FAIL stall_b_hold got=%h exp=0002", ifc.b); end
        ifc.out_ready = 1'b1;
        #1;
        vec++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", ifc.in_ready); end
        @(negedge clk);
        stop();
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL stall_ov2 got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'hAA) begin bad++; $display("FAIL stall_a2 got=%h exp=aa", ifc.a); end
        vec++; if (ifc.b !== 16'hCCBB) begin bad++; $display("FAIL stall_b2 got=%h exp=ccbb", ifc.b); end
        @(negedge clk);
        vec++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL stall_ov_drop got=%b exp=0", ifc.out_valid); end
    endtask

    task automatic test_resync();
        int t;
        ifc.out_ready = 1'b1;
        send(8'h07, 1'b1, t);
        send(8'h10, 1'b0, t);
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL resync_err_pre got=%b exp=0", ifc.err); end
        send(8'h09, 1'b1, t);
        vec++; if (ifc.err !== 1'b1) begin bad++; $display("FAIL resync_err got=%b exp=1", ifc.err); end
        vec++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL resync_ov got=%b exp=0", ifc.out_valid); end
        send(8'hCD, 1'b0, t);
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL resync_err_pulse got=%b exp=0", ifc.err); end
        send(8'hAB, 1'b0, t);
`ifdef IF_PACK_CKSUM_EN
        send(8'h09 ^ 8'hCD ^ 8'hAB, 1'b0, t);
`endif
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL resync_ov2 got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h09) begin bad++; $display("FAIL resync_a got=%h exp=09", ifc.a); end
        vec++; if (ifc.b !== 16'hABCD) begin bad++; $display("FAIL resync_b got=%h exp=abcd", ifc.b); end
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL resync_err_end got=%b exp=0", ifc.err); end
        stop();
        @(negedge clk);
    endtask

`ifdef IF_PACK_CKSUM_EN
    task automatic test_cksum();
        int t;
        ifc.out_ready = 1'b1;
        send(8'h05, 1'b1, t);
        send(8'h34, 1'b0, t);
        send(8'h12, 1'b0, t);
        send(8'h23, 1'b0, t);
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL cksum_ov got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h05) begin bad++; $display("FAIL cksum_a got=%h exp=05", ifc.a); end
        vec++; if (ifc.b !== 16'h1234) begin bad++; $display("FAIL cksum_b got=%h exp=1234", ifc.b); end
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL cksum_err_ok got=%b exp=0", ifc.err); end
        send(8'h06, 1'b1, t);
        send(8'h35, 1'b0, t);
        send(8'h13, 1'b0, t);
        send(8'h24, 1'b0, t);
        vec++; if (ifc.err !== 1'b1) begin bad++; $display("FAIL cksum_err got=%b exp=1", ifc.err); end
        vec++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL cksum_bad_ov got=%b exp=0", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h05) begin bad++; $display("FAIL cksum_bad_a got=%h exp=05", ifc.a); end
        vec++; if (ifc.b !== 16'h1234) begin bad++; $display("FAIL cksum_bad_b got=%h exp=1234", ifc.b); end
        stop();
        @(negedge clk);
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL cksum_err_pulse got=%b exp=0", ifc.err); end
    endtask
`endif

    task automatic test_reset_mid();
        int t, w;
        ifc.out_ready = 1'b1;
        send(8'h11, 1'b1, t);
        send(8'h22, 1'b0, t);
        rst_n = 1'b0;
        stop();
        #1;
        vec++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_ov got=%b exp=0", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h00) begin bad++; $display("FAIL rstmid_a got=%h exp=00", ifc.a); end
        vec++; if (ifc.b !== 16'h0000) begin bad++; $display("FAIL rstmid_b got=%h exp=0000", ifc.b); end
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b exp=0", ifc.err); end
        vec++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ifc.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(8'h31, 8'h42, 8'h53, w);
        vec++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_ov2 got=%b exp=1", ifc.out_valid); end
        vec++; if (ifc.a !== 8'h31) begin bad++; $display("FAIL rstmid_a2 got=%h exp=31", ifc.a); end
        vec++; if (ifc.b !== 16'h5342) begin bad++; $display("FAIL rstmid_b2 got=%h exp=5342", ifc.b); end
        vec++; if (ifc.err !== 1'b0) begin bad++; $display("FAIL rstmid_err2 got=%b exp=0", ifc.err); end
        stop();
        @(negedge clk);
    endtask

    initial begin
        ifc.in_data   = 8'h00;
        ifc.in_valid  = 1'b0;
        ifc.in_first  = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_resync();
`ifdef IF_PACK_CKSUM_EN
        test_cksum();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
